// File: rtl/spi_frame_reader.sv
// SPI master that reads one NBITS-wide interlock frame from the input CPLD per request.
// Optional build macro AUTO_POLL_EN adds a free-running poll timer that issues periodic frame requests.
module spi_frame_reader #(
    parameter int NBITS    = 75,
    parameter int HALF     = 8,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int MIN_GAP  = 16
`ifdef AUTO_POLL_EN
    ,
    parameter int POLL_PERIOD = 50000
`endif
) (
    input  logic             pclk_50M,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic [0:NBITS-1] data_out,
    output logic             data_valid,
    output logic             spi_cs,
    output logic             spi_clk,
    input  logic             miso
);

    localparam int PERIOD = 2 * HALF;
    localparam int CMAX_A = (PERIOD > CS_SETUP) ? PERIOD : CS_SETUP;
    localparam int CMAX_B = (CS_HOLD > MIN_GAP) ? CS_HOLD : MIN_GAP;
    localparam int CMAX   = (CMAX_A > CMAX_B) ? CMAX_A : CMAX_B;
    localparam int CW     = $clog2(CMAX + 1);
    localparam int BW     = (NBITS > 1) ? $clog2(NBITS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
    logic             cs_nxt, clk_nxt, busy_nxt, valid_nxt;
    logic             capture, publish;
    logic             miso_meta, miso_sync;
    logic [0:NBITS-1] shift_reg;
    logic             start_req;

`ifdef AUTO_POLL_EN
    localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

    logic [PW-1:0] poll_cnt;
    logic          poll_tick;

    always_ff @(posedge pclk_50M) begin
        if (rst) begin
            poll_cnt <= '0;
        end else if (poll_cnt == PW'(POLL_PERIOD - 1)) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + PW'(1);
        end
    end

    // Tick on count zero so the first poll fires right after reset release.
    assign poll_tick = (poll_cnt == '0);
    assign start_req = start | poll_tick;
`else
    assign start_req = start;
`endif

    always_ff @(posedge pclk_50M) begin
        if (rst) begin
            miso_meta <= 1'b0;
            miso_sync <= 1'b0;
        end else begin
            miso_meta <= miso;
            miso_sync <= miso_meta;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + CW'(1);
        bit_cnt_nxt = bit_cnt;
        cs_nxt      = spi_cs;
        clk_nxt     = spi_clk;
        busy_nxt    = busy;
        valid_nxt   = 1'b0;
        capture     = 1'b0;
        publish     = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (start_req) begin
                    state_nxt = SETUP;
                    cs_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            SETUP: begin
                if (cnt == CW'(CS_SETUP - 1)) begin
                    state_nxt   = SHIFT;
                    cnt_nxt     = '0;
                    bit_cnt_nxt = '0;
                    clk_nxt     = 1'b1;
                end
            end
            SHIFT: begin
                // Each period is high phase then low phase; sample at the end of the high phase.
                if (cnt == CW'(HALF - 1)) begin
                    clk_nxt = 1'b0;
                    capture = 1'b1;
                end else if (cnt == CW'(PERIOD - 1)) begin
                    cnt_nxt = '0;
                    if (bit_cnt == BW'(NBITS - 1)) begin
                        state_nxt = HOLD;
                    end else begin
                        clk_nxt     = 1'b1;
                        bit_cnt_nxt = bit_cnt + BW'(1);
                    end
                end
            end
            HOLD: begin
                if (cnt == CW'(CS_HOLD - 1)) begin
                    state_nxt = GAP;
                    cnt_nxt   = '0;
                    cs_nxt    = 1'b1;
                    valid_nxt = 1'b1;
                    publish   = 1'b1;
                end
            end
            GAP: begin
                if (cnt == CW'(MIN_GAP - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                cs_nxt    = 1'b1;
                clk_nxt   = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pclk_50M) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            spi_cs     <= 1'b1;
            spi_clk    <= 1'b0;
            busy       <= 1'b0;
            data_valid <= 1'b0;
            shift_reg  <= '0;
            data_out   <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            spi_cs     <= cs_nxt;
            spi_clk    <= clk_nxt;
            busy       <= busy_nxt;
            data_valid <= valid_nxt;
            if (capture) begin
                shift_reg <= {shift_reg[1:NBITS-1], miso_sync};
            end
            if (publish) begin
                data_out <= shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_reader.sv
// Self-checking bench for spi_frame_reader: SPI slave model, frame scoreboard and link monitor.
module tb_spi_frame_reader;

    localparam int NB = 75;
    localparam logic [0:NB-1] PAT =
        75'b0101_1101_0101_1101_0101_1101_0101_1101_0101_1101_0101_1101_0101_1101_0101_1101_01_0111_0110_1;

    logic          pclk_50M = 1'b0;
    logic          rst      = 1'b1;
    logic          start    = 1'b0;
    logic          miso     = 1'b0;
    logic          busy, data_valid, spi_cs, spi_clk;
    logic [0:NB-1] data_out;

    spi_frame_reader #(
        .NBITS   (NB),
        .HALF    (8),
        .CS_SETUP(4),
        .CS_HOLD (4),
        .MIN_GAP (16)
`ifdef AUTO_POLL_EN
        ,
        .POLL_PERIOD(2000)
`endif
    ) dut (
        .pclk_50M  (pclk_50M),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .data_out  (data_out),
        .data_valid(data_valid),
        .spi_cs    (spi_cs),
        .spi_clk   (spi_clk),
        .miso      (miso)
    );

    always #10 pclk_50M = ~pclk_50M;

    typedef struct {
        logic [0:NB-1] frame;
        int            at;
    } exp_t;

    exp_t          sb[$];
    int            passed = 0, total = 0;
    int            cyc = 0;
    int            valids = 0, rises = 0, first_rise = -1, last_rise = -1;
    int            period_err = 0, edge_cs_high = 0, gap_err = 0, dout_err = 0;
    int            cs_rise_at = -1;
    bit            poll_mode = 1'b0;
    logic [0:NB-1] slave_pat = '0;

    initial forever begin
        @(posedge pclk_50M);
        cyc++;
    end

    // Slave: bit 0 presented while deselected, next bit after every falling spi_clk.
    initial begin : slave
        int   sidx;
        logic last_clk;
        sidx     = 0;
        last_clk = 1'b0;
        forever begin
            @(spi_cs or spi_clk or slave_pat);
            if (spi_cs) begin
                sidx = 0;
                miso = slave_pat[0];
            end else if (last_clk && !spi_clk) begin
                sidx++;
                miso = (sidx < NB) ? slave_pat[sidx] : 1'b0;
            end
            last_clk = spi_clk;
        end
    end

    initial begin : monitor
        logic          last_clk_m, last_cs_m;
        logic [0:NB-1] last_dout;
        exp_t          e;
        last_clk_m = 1'b0;
        last_cs_m  = 1'b1;
        last_dout  = '0;
        forever begin
            @(negedge pclk_50M);
            if (spi_clk && !last_clk_m) begin
                if (spi_cs) edge_cs_high++;
                if (last_rise >= 0 && cyc - last_rise != 16) period_err++;
                if (first_rise < 0) first_rise = cyc;
                last_rise = cyc;
                rises++;
            end
            if (!spi_clk && last_clk_m && spi_cs && !rst) edge_cs_high++;
            if (!spi_cs && last_cs_m) begin
                if (cs_rise_at >= 0 && cyc - cs_rise_at < 16) gap_err++;
                rises      = 0;
                first_rise = -1;
                last_rise  = -1;
                period_err = 0;
            end
            if (spi_cs && !last_cs_m) cs_rise_at = cyc;
            if (!rst && data_out !== last_dout && data_valid !== 1'b1) dout_err++;
            if (data_valid === 1'b1) begin
                valids++;
                if (!poll_mode) begin
                    total++;
                    if (sb.size() == 0) begin
                        $display("FAIL frame_unexpected: data_valid at cycle %0d with no frame outstanding", cyc);
                    end else begin
                        e = sb.pop_front();
                        if (data_out !== e.frame || cyc !== e.at)
                            $display("FAIL frame: got %h at cycle %0d, expected %h at cycle %0d",
                                     data_out, cyc, e.frame, e.at);
                        else passed++;
                    end
                end
            end
            last_clk_m = spi_clk;
            last_cs_m  = spi_cs;
            last_dout  = data_out;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge pclk_50M);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge pclk_50M);
            total++;
            if ({spi_cs, spi_clk, busy, data_valid} !== 4'b1000 || data_out !== '0)
                $display("FAIL reset_idle: cyc %0d cs/clk/busy/valid=%b data_out=%h, expected 1000 and 0",
                         i, {spi_cs, spi_clk, busy, data_valid}, data_out);
            else passed++;
        end
    endtask

    task automatic test_single_frame();
        int t0, n, v0;
        slave_pat = PAT;
        v0 = valids;
        @(negedge pclk_50M);
        t0    = cyc;
        start = 1'b1;
        sb.push_back('{PAT, t0 + 1209});
        @(negedge pclk_50M);
        start = 1'b0;
        total++;
        if (spi_cs !== 1'b0 || busy !== 1'b1)
            $display("FAIL cs_fall: cs=%b busy=%b at cycle 1, expected cs=0 busy=1", spi_cs, busy);
        else passed++;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            @(negedge pclk_50M);
            n++;
        end
        total++;
        if (cyc - t0 !== 1225) $display("FAIL busy_fall: at cycle %0d, expected 1225", cyc - t0);
        else passed++;
        total++;
        if (rises !== 75 || first_rise - t0 !== 5 || period_err !== 0)
            $display("FAIL spi_clk: rises=%0d first=%0d period_err=%0d, expected 75, 5, 0",
                     rises, first_rise - t0, period_err);
        else passed++;
        total++;
        if (valids - v0 !== 1) $display("FAIL valid_count: got %0d expected 1", valids - v0);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int t0, t1, n, v0;
        slave_pat = '1;
        v0 = valids;
        @(negedge pclk_50M);
        t0    = cyc;
        start = 1'b1;
        sb.push_back('{'1, t0 + 1209});
        @(negedge pclk_50M);
        start = 1'b0;
        repeat (1223) @(negedge pclk_50M);
        start     = 1'b1;
        slave_pat = '0;
        @(negedge pclk_50M);
        total++;
        if (busy !== 1'b0 || spi_cs !== 1'b1 || data_out !== '1)
            $display("FAIL start_on_busy_fall: busy=%b cs=%b data_out=%h, expected 0 1 all-ones",
                     busy, spi_cs, data_out);
        else passed++;
        t1 = cyc;
        sb.push_back('{'0, t1 + 1209});
        @(negedge pclk_50M);
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || spi_cs !== 1'b0)
            $display("FAIL second_start: busy=%b cs=%b, expected 1 0", busy, spi_cs);
        else passed++;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            @(negedge pclk_50M);
            n++;
        end
        total++;
        if (cyc - t1 !== 1225 || rises !== 75)
            $display("FAIL b2b_frame: busy fell at %0d rises=%0d, expected 1225 75", cyc - t1, rises);
        else passed++;
        total++;
        if (valids - v0 !== 2) $display("FAIL b2b_valids: got %0d expected 2", valids - v0);
        else passed++;
    endtask

    task automatic test_start_during_shift();
        int t0, n, v0;
        slave_pat = ~PAT;
        v0 = valids;
        @(negedge pclk_50M);
        t0    = cyc;
        start = 1'b1;
        sb.push_back('{~PAT, t0 + 1209});
        @(negedge pclk_50M);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            repeat (50) @(negedge pclk_50M);
            start = 1'b1;
            @(negedge pclk_50M);
            start = 1'b0;
        end
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            @(negedge pclk_50M);
            n++;
        end
        total++;
        if (cyc - t0 !== 1225) $display("FAIL ignore_start: busy fell at %0d, expected 1225", cyc - t0);
        else passed++;
        repeat (40) @(negedge pclk_50M);
        total++;
        if (valids - v0 !== 1 || busy !== 1'b0 || spi_cs !== 1'b1 || sb.size() !== 0)
            $display("FAIL ignore_start_tail: valids=%0d busy=%b cs=%b pending=%0d, expected 1 0 1 0",
                     valids - v0, busy, spi_cs, sb.size());
        else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int t0, n, v0;
        slave_pat = PAT;
        @(negedge pclk_50M);
        start = 1'b1;
        sb.push_back('{PAT, -1});
        @(negedge pclk_50M);
        start = 1'b0;
        n = 0;
        while (rises !== 40 && n < 1000) begin
            @(negedge pclk_50M);
            n++;
        end
        total++;
        if (rises !== 40) $display("FAIL reach_40_rises: got %0d expected 40", rises);
        else passed++;
        rst = 1'b1;
        sb.delete();
        v0 = valids;
        @(negedge pclk_50M);
        total++;
        if ({spi_cs, spi_clk, busy, data_valid} !== 4'b1000 || data_out !== '0)
            $display("FAIL mid_reset: cs/clk/busy/valid=%b data_out=%h, expected 1000 and 0",
                     {spi_cs, spi_clk, busy, data_valid}, data_out);
        else passed++;
        @(negedge pclk_50M);
        rst = 1'b0;
        repeat (30) @(negedge pclk_50M);
        total++;
        if (valids !== v0) $display("FAIL mid_reset_valid: got %0d pulses expected 0", valids - v0);
        else passed++;
        @(negedge pclk_50M);
        t0    = cyc;
        start = 1'b1;
        sb.push_back('{PAT, t0 + 1209});
        @(negedge pclk_50M);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            @(negedge pclk_50M);
            n++;
        end
        total++;
        if (cyc - t0 !== 1225 || rises !== 75 || valids - v0 !== 1)
            $display("FAIL post_reset_frame: busy fell %0d rises=%0d valids=%0d, expected 1225 75 1",
                     cyc - t0, rises, valids - v0);
        else passed++;
    endtask

`ifdef AUTO_POLL_EN
    task automatic test_auto_poll();
        int v0;
        poll_mode = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge pclk_50M);
        v0  = valids;
        rst = 1'b0;
        repeat (10000) @(negedge pclk_50M);
        total++;
        if (valids - v0 !== 5) $display("FAIL auto_poll: got %0d frames expected 5", valids - v0);
        else passed++;
    endtask
`endif

    task automatic test_link_invariants();
        total++;
        if (edge_cs_high !== 0 || gap_err !== 0 || dout_err !== 0)
            $display("FAIL link_rules: clk_edges_cs_high=%0d short_gaps=%0d stray_dout=%0d, expected 0 0 0",
                     edge_cs_high, gap_err, dout_err);
        else passed++;
    endtask

    initial begin
`ifdef AUTO_POLL_EN
        test_auto_poll();
`else
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_start_during_shift();
        test_reset_mid_frame();
`endif
        test_link_invariants();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
